qpu_ifu_ir_stage: RTL and testbench

//  Fetch/IR stage directly upstream of exu decode. Generates the PC and issues one fetch at a time to instruction memory.

---
 rtl/qpu_ifu_ir_stage_if.sv | 41 ++++
 rtl/qpu_ifu_ir_stage.sv | 177 +++++++++++++++++
 tb/tb_qpu_ifu_ir_stage.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qpu_ifu_ir_stage_if.sv
// Fetch/IR stage bus bundle: instruction-memory request/response, commit
// redirect, fetch halt and the IR handshake towards decode.
// master = the fetch stage, slave = memory/commit/decode side.
interface qpu_ifu_ir_stage_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
);
  // Instruction-memory request / response
  logic               ifu_req_valid;
  logic               ifu_req_ready;
  logic [PC_W-1:0]    ifu_req_pc;
  logic               ifu_rsp_valid;
  logic               ifu_rsp_ready;
  logic [INSTR_W-1:0] ifu_rsp_instr;
  // Redirect from commit / BJP
  logic               pipe_flush_req;
  logic [PC_W-1:0]    pipe_flush_pc;
  logic               pipe_flush_ack;
  // Fetch throttle
  logic               ifu_halt;
  // IR entry towards decode
  logic               ifu_o_valid;
  logic               ifu_o_ready;
  logic [INSTR_W-1:0] ifu_o_ir;
  logic [PC_W-1:0]    ifu_o_pc;
  logic               ifu_o_prdt_taken;

  modport master (
    output ifu_req_valid, ifu_req_pc, ifu_rsp_ready, pipe_flush_ack,
           ifu_o_valid, ifu_o_ir, ifu_o_pc, ifu_o_prdt_taken,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr,
           pipe_flush_req, pipe_flush_pc, ifu_halt, ifu_o_ready
  );

  modport slave (
    input  ifu_req_valid, ifu_req_pc, ifu_rsp_ready, pipe_flush_ack,
           ifu_o_valid, ifu_o_ir, ifu_o_pc, ifu_o_prdt_taken,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr,
           pipe_flush_req, pipe_flush_pc, ifu_halt, ifu_o_ready
  );
endinterface

// File: rtl/qpu_ifu_ir_stage.sv
// Fetch/IR stage in front of exu decode. Issues one word-aligned fetch at a
// time, buffers returned instructions in an IR FIFO (slot reserved at issue,
// so responses never need backpressure) and hands {instr, pc, prdt_taken}
// to decode. Commit flush redirects the PC and discards in-flight data.
// Optional feature: define QPU_IFU_STATIC_BPU_EN to predict backward
// branches taken; otherwise next PC is always pc+4 and prdt_taken is 0.
module qpu_ifu_ir_stage #(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter int              IR_DEPTH = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  qpu_ifu_ir_stage_if.master  bus
);

  localparam int PTR_W = (IR_DEPTH > 1) ? $clog2(IR_DEPTH) : 1;
  localparam int CNT_W = $clog2(IR_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(IR_DEPTH);
  localparam logic [PC_W-1:0]  ALIGN_MASK = {{(PC_W-2){1'b1}}, 2'b00};
  localparam logic [PC_W-1:0]  PC_STEP    = PC_W'(4);

  typedef enum logic [1:0] {
    S_IDLE,  // may issue when not halted and a FIFO slot is free
    S_REQ,   // request held stable until the memory accepts it
    S_WAIT,  // one fetch outstanding, its FIFO slot reserved
    S_DROP   // outstanding fetch was flushed, discard its response
  } state_t;

  state_t            state_q;
  logic              req_valid_q;
  logic [PC_W-1:0]   pc_q;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [INSTR_W-1:0] ir_mem   [IR_DEPTH];
  logic [PC_W-1:0]    pc_mem   [IR_DEPTH];
  logic               prdt_mem [IR_DEPTH];

  logic              flush;
  logic              push;
  logic              pop;
  logic              o_valid;
  logic              prdt_taken;
  logic [PC_W-1:0]   next_pc;
  logic [PC_W-1:0]   flush_pc_a;

  assign flush      = bus.pipe_flush_req;
  assign flush_pc_a = bus.pipe_flush_pc & ALIGN_MASK;
  assign o_valid    = (cnt_q != '0);
  // A flush wins over both the response write and the decode pop.
  assign push       = (state_q == S_WAIT) & bus.ifu_rsp_valid & ~flush;
  assign pop        = o_valid & bus.ifu_o_ready & ~flush;

`ifdef QPU_IFU_STATIC_BPU_EN
  logic            is_branch;
  logic [15:0]     br_off16;
  logic [PC_W-1:0] br_off;

  // Static prediction: backward (sign bit set) conditional branches taken.
  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    is_branch  = ~bus.ifu_rsp_instr[0] & (bus.ifu_rsp_instr[4:0] == 5'b11000);
    prdt_taken = is_branch & bus.ifu_rsp_instr[9];
    br_off16   = {bus.ifu_rsp_instr[9:5], bus.ifu_rsp_instr[23:15], 2'b00};
    br_off     = {{(PC_W-16){br_off16[15]}}, br_off16};
    next_pc    = prdt_taken ? (pc_q + br_off) : (pc_q + PC_STEP);
  end
`else
  // No prediction: sequential fetch, branches resolved later by flush.
  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    prdt_taken = 1'b0;
    next_pc    = pc_q + PC_STEP;
  end
`endif

  // Fetch FSM and PC; flush overrides every state.
  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_valid_q <= 1'b0;
      pc_q        <= RESET_PC & ALIGN_MASK;
    end else if (flush) begin
      pc_q <= flush_pc_a;
      case (state_q)
        S_REQ: begin
          if (bus.ifu_req_ready) begin
            state_q     <= S_DROP;
            req_valid_q <= 1'b0;
          end
        end
        S_WAIT, S_DROP: begin
          state_q <= bus.ifu_rsp_valid ? S_IDLE : S_DROP;
        end
        default: state_q <= S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!bus.ifu_halt && (cnt_q < FULL_CNT)) begin
            state_q     <= S_REQ;
            req_valid_q <= 1'b1;
          end
        end
        S_REQ: begin
          if (bus.ifu_req_ready) begin
            state_q     <= S_WAIT;
            req_valid_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (bus.ifu_rsp_valid) begin
            state_q <= S_IDLE;
            pc_q    <= next_pc;
          end
        end
        default: begin
          if (bus.ifu_rsp_valid) state_q <= S_IDLE;
        end
      endcase
    end
  end

  // FIFO pointer/count next state; pointers wrap naturally (power-of-2 depth).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // FIFO control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // IR payload write on an accepted response.
  // NOTE: payload storage has no reset; entries are only visible through the reset count, and outputs are masked when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      ir_mem[wr_ptr_q]   <= bus.ifu_rsp_instr;
      pc_mem[wr_ptr_q]   <= pc_q;
      prdt_mem[wr_ptr_q] <= prdt_taken;
    end
  end

  assign bus.ifu_req_valid    = req_valid_q;
  assign bus.ifu_req_pc       = pc_q;
  assign bus.ifu_rsp_ready    = 1'b1;
  assign bus.pipe_flush_ack   = bus.pipe_flush_req;
  assign bus.ifu_o_valid      = o_valid;
  assign bus.ifu_o_ir         = o_valid ? ir_mem[rd_ptr_q]   : '0;
  assign bus.ifu_o_pc         = o_valid ? pc_mem[rd_ptr_q]   : '0;
  assign bus.ifu_o_prdt_taken = o_valid ? prdt_mem[rd_ptr_q] : 1'b0;

endmodule

// File: tb/tb_qpu_ifu_ir_stage.sv
// Bench for qpu_ifu_ir_stage: a memory model answers fetches, directed
// stimulus drives halt/flush/ready, and a scoreboard monitor checks every
// IR entry popped by decode against the expected queue.
module tb_qpu_ifu_ir_stage;
  localparam int          PC_W     = 32;
  localparam int          INSTR_W  = 32;
  localparam int          IR_DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] BR_PC    = 32'h10;
  // Branch, instr[9]=1, 14-bit imm = -4 words -> target BR_PC - 16.
  localparam logic [31:0] BR_INSTR = 32'h00FE_03F8;
`ifdef QPU_IFU_STATIC_BPU_EN
  localparam bit PRDT_EN = 1'b1;
`else
  localparam bit PRDT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
    logic        prdt;
  } ir_ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qpu_ifu_ir_stage_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  qpu_ifu_ir_stage #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .IR_DEPTH(IR_DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  ir_ent_t     exp_q [$];
  logic [31:0] seen_q[$];

  // Stimulus controls, applied to the bus at each falling edge by tick().
  bit          flush_ctl    = 0;
  logic [31:0] flush_pc_ctl = '0;
  bit          halt_ctl     = 0;
  bit          o_ready_ctl  = 1;
  bit          req_ready_ctl = 1;
  int          lat          = 0;
  bit          br_en        = 0;

  // Memory model state.
  bit          pending   = 0;
  logic [31:0] pend_pc   = '0;
  int          pend_wait = 0;
  bit          pend_drop = 0;
  int          n_hs      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] instr_at(input logic [31:0] pc);
    if (br_en && pc == BR_PC) return BR_INSTR;
    return {pc[27:0], 4'h1};
  endfunction

  function automatic logic exp_prdt(input logic [31:0] pc);
    return PRDT_EN && br_en && (pc == BR_PC);
  endfunction

  // One clock: drive inputs at the falling edge, run the memory model,
  // and push the expected IR entry when a surviving response is issued.
  task automatic tick();
    @(negedge clk);
    bus.pipe_flush_req = flush_ctl;
    bus.pipe_flush_pc  = flush_pc_ctl;
    bus.ifu_halt       = halt_ctl;
    bus.ifu_o_ready    = o_ready_ctl;
    bus.ifu_req_ready  = req_ready_ctl;
    bus.ifu_rsp_valid  = 1'b0;
    if (!rst_n) begin
      pending = 0;
      return;
    end
    if (flush_ctl) exp_q.delete();
    if (pending) begin
      if (pend_wait == 0) begin
        pending = 0;
        bus.ifu_rsp_valid = 1'b1;
        bus.ifu_rsp_instr = instr_at(pend_pc);
        if (!pend_drop && !flush_ctl)
          exp_q.push_back('{ir: instr_at(pend_pc), pc: pend_pc, prdt: exp_prdt(pend_pc)});
      end else begin
        pend_wait--;
        if (flush_ctl) pend_drop = 1;
      end
    end
    if (bus.ifu_req_valid && req_ready_ctl) begin
      pending   = 1;
      pend_pc   = bus.ifu_req_pc;
      pend_wait = lat;
      pend_drop = flush_ctl;
      seen_q.push_back(bus.ifu_req_pc);
      n_hs++;
    end
  endtask

  task automatic run_until_seen(input int n, input string name);
    int k = 0;
    while (seen_q.size() < n && k < 200) begin
      tick();
      k++;
    end
    check(name, seen_q.size() >= n, 1);
  endtask

  // Scoreboard monitor: every decode pop is compared with the queue head.
  initial begin
    ir_ent_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && bus.ifu_o_valid && bus.ifu_o_ready && !bus.pipe_flush_req) begin
        check("sb_has_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("o_ir", bus.ifu_o_ir, e.ir);
          check("o_pc", bus.ifu_o_pc, e.pc);
          check("o_prdt", bus.ifu_o_prdt_taken, e.prdt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t1_exp [4];
    logic [31:0] pc0;
    int base;
    int k;
    t1_exp = '{32'h0, 32'h4, 32'h8, 32'hC};

    bus.pipe_flush_req = 1'b0;
    bus.pipe_flush_pc  = '0;
    bus.ifu_halt       = 1'b0;
    bus.ifu_o_ready    = 1'b1;
    bus.ifu_req_ready  = 1'b1;
    bus.ifu_rsp_valid  = 1'b0;
    bus.ifu_rsp_instr  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_valid", bus.ifu_req_valid, 0);
    check("rst_req_pc", bus.ifu_req_pc, RESET_PC);
    check("rst_o_valid", bus.ifu_o_valid, 0);
    check("rst_o_ir", bus.ifu_o_ir, 0);
    check("rst_o_pc", bus.ifu_o_pc, 0);
    check("rst_o_prdt", bus.ifu_o_prdt_taken, 0);
    check("rsp_ready", bus.ifu_rsp_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: sequential fetch 0,4,8,C
    run_until_seen(4, "t1_fetch_progress");
    halt_ctl = 1;
    repeat (10) tick();
    for (int i = 0; i < 4; i++) check($sformatf("t1_req_pc%0d", i), seen_q[i], t1_exp[i]);
    check("t1_sb_drained", exp_q.size(), 0);

    // 2: branch at 0x10 with imm -4 words
    seen_q.delete();
    br_en = 1;
    halt_ctl = 0;
    run_until_seen(2, "t2_fetch_progress");
    halt_ctl = 1;
    repeat (10) tick();
    br_en = 0;
    check("t2_br_pc", seen_q[0], 32'h10);
    check("t2_next_pc", seen_q[1], PRDT_EN ? 32'h0 : 32'h14);
    check("t2_sb_drained", exp_q.size(), 0);

    // 3: decode stalled -> exactly IR_DEPTH fetches, then release in order
    base = n_hs;
    o_ready_ctl = 0;
    halt_ctl = 0;
    repeat (20) tick();
    #1;
    check("t3_fetches_while_full", n_hs - base, 2);
    check("t3_req_valid_low", bus.ifu_req_valid, 0);
    check("t3_o_valid_held", bus.ifu_o_valid, 1);
    o_ready_ctl = 1;
    halt_ctl = 1;
    repeat (10) tick();
    check("t3_sb_drained", exp_q.size(), 0);

    // 4: flush to 0x200 while waiting for a slow response
    lat = 3;
    halt_ctl = 0;
    k = 0;
    while (!pending && k < 50) begin tick(); k++; end
    check("t4_handshake", pending, 1);
    flush_ctl = 1;
    flush_pc_ctl = 32'h200;
    tick();
    #1;
    check("t4_flush_ack", bus.pipe_flush_ack, 1);
    flush_ctl = 0;
    seen_q.delete();
    tick();
    #1;
    check("t4_o_valid_after_flush", bus.ifu_o_valid, 0);
    run_until_seen(1, "t4_fetch_progress");
    halt_ctl = 1;
    repeat (15) tick();
    check("t4_redirect_pc", seen_q[0], 32'h200);
    check("t4_sb_drained", exp_q.size(), 0);
    lat = 0;

    // 5: request held while memory not ready; flush on cycle 3 retargets it
    req_ready_ctl = 0;
    halt_ctl = 0;
    k = 0;
    do begin tick(); #1; k++; end while (!bus.ifu_req_valid && k < 50);
    check("t5_req_valid", bus.ifu_req_valid, 1);
    pc0 = 32'h204;
    check("t5_req_pc_initial", bus.ifu_req_pc, pc0);
    flush_pc_ctl = 32'h300;
    for (int i = 1; i <= 5; i++) begin
      flush_ctl = (i == 3);
      tick();
      #1;
      check($sformatf("t5_valid_c%0d", i), bus.ifu_req_valid, 1);
      check($sformatf("t5_pc_c%0d", i), bus.ifu_req_pc, (i <= 3) ? pc0 : 32'h300);
    end
    flush_ctl = 0;
    req_ready_ctl = 1;
    seen_q.delete();
    run_until_seen(1, "t5_fetch_progress");
    halt_ctl = 1;
    repeat (10) tick();
    check("t5_accepted_pc", seen_q[0], 32'h300);

    // 6: async reset during WAIT with an entry buffered and one in flight
    lat = 3;
    o_ready_ctl = 0;
    halt_ctl = 0;
    base = n_hs;
    k = 0;
    while (n_hs < base + 2 && k < 60) begin tick(); k++; end
    tick();
    #1;
    check("t6_o_valid_before", bus.ifu_o_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_o_valid_reset", bus.ifu_o_valid, 0);
    check("t6_req_valid_reset", bus.ifu_req_valid, 0);
    check("t6_req_pc_reset", bus.ifu_req_pc, RESET_PC);
    pending = 0;
    exp_q.delete();
    bus.ifu_rsp_valid = 1'b0;
    lat = 0;
    o_ready_ctl = 1;
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    seen_q.delete();
    run_until_seen(1, "t6_fetch_progress");
    halt_ctl = 1;
    repeat (10) tick();
    check("t6_first_pc", seen_q[0], RESET_PC);
    check("t6_sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
